// File: rtl/cmp_share_arb_pkg.sv
// Shared definitions for the cmp_share_arb comparator-sharing arbiter.
//   state_t          : sequencer states (IDLE -> CMP -> DONE -> IDLE)
//   NREQ_DEF / W_DEF : default requester count and operand width
//   RES_*            : bit positions of eq/lt/gt in the registered result vector
package cmp_share_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;

  localparam int RES_EQ = 0;
  localparam int RES_LT = 1;
  localparam int RES_GT = 2;
  localparam int RES_W  = 3;

endpackage

// File: rtl/cmp_share_arb_cmp_core.sv
// Purely combinational unsigned magnitude comparator shared by all requesters.
// Ports:
//   i_a, i_b : W-bit unsigned operands
//   o_eq     : i_a == i_b
//   o_lt     : i_a <  i_b
//   o_gt     : i_a >  i_b
module cmp_core #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_eq,
  output logic         o_lt,
  output logic         o_gt
);

  assign o_eq = (i_a == i_b);
  assign o_lt = (i_a <  i_b);
  assign o_gt = (i_a >  i_b);

endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter/sequencer sharing one comparator among NREQ requesters.
// One transaction takes three cycles: grant + operand capture, compare,
// response. Results are registered and visible only while rsp_valid != 0.
// Ports:
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   req[NREQ]        : level request per requester
//   a_in, b_in       : packed operands, requester i uses [i*W +: W]
//   gnt[NREQ]        : registered one-hot grant, held through CMP and DONE
//   busy             : transaction in flight
//   rsp_valid[NREQ]  : one-cycle one-hot response strobe
//   rsp_eq/lt/gt     : comparison result, exactly one set while rsp_valid != 0
module cmp_share_arb
  import cmp_share_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_eq,
  output logic              rsp_lt,
  output logic              rsp_gt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [RES_W-1:0]  r_res;
  logic [W-1:0]      r_op_a;
  logic [W-1:0]      r_op_b;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_win;
  logic [PW-1:0]     w_win;
  logic [PW-1:0]     w_ptr_nxt;
  logic [NREQ-1:0]   w_win_oh;
  logic [W-1:0]      w_sel_a;
  logic [W-1:0]      w_sel_b;
  logic              w_eq;
  logic              w_lt;
  logic              w_gt;

  // First asserted request at or above the pointer wins; if none, wrap to the
  // lowest asserted request below it. Splitting the scan in two avoids a
  // modulo on non-power-of-two NREQ.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [PW-1:0]   p);
    logic [PW-1:0] sel_hi;
    logic [PW-1:0] sel_lo;
    logic          found_hi;
    sel_hi   = '0;
    sel_lo   = '0;
    found_hi = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (r[i]) begin
        sel_lo = PW'(i);
        if (i >= int'(p)) begin
          sel_hi   = PW'(i);
          found_hi = 1'b1;
        end
      end
    end
    return found_hi ? sel_hi : sel_lo;
  endfunction

  assign w_win     = rr_pick(req, r_ptr);
  assign w_ptr_nxt = (r_win == PW'(NREQ - 1)) ? '0 : r_win + 1'b1;

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_win_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == PW'(i)) begin
        w_sel_a     = a_in[i*W +: W];
        w_sel_b     = b_in[i*W +: W];
        w_win_oh[i] = 1'b1;
      end
    end
  end

  cmp_core #(.W(W)) u_cmp_core (
    .i_a  (r_op_a),
    .i_b  (r_op_b),
    .o_eq (w_eq),
    .o_lt (w_lt),
    .o_gt (w_gt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|req) w_state_nxt = CMP;
      CMP:     w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_res       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_ptr       <= '0;
      r_win       <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        // grant and capture operands; later a_in/b_in changes are ignored
        IDLE: begin
          if (|req) begin
            r_gnt  <= w_win_oh;
            r_win  <= w_win;
            r_op_a <= w_sel_a;
            r_op_b <= w_sel_b;
          end
        end
        // register result, strobe the granted requester, rotate priority
        CMP: begin
          r_res[RES_EQ] <= w_eq;
          r_res[RES_LT] <= w_lt;
          r_res[RES_GT] <= w_gt;
          r_rsp_valid   <= r_gnt;
          r_ptr         <= w_ptr_nxt;
        end
        // response seen for one cycle; release everything
        DONE: begin
          r_gnt       <= '0;
          r_rsp_valid <= '0;
          r_res       <= '0;
        end
        default: begin
          r_gnt       <= '0;
          r_rsp_valid <= '0;
          r_res       <= '0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign busy      = (r_state != IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_eq    = r_res[RES_EQ];
  assign rsp_lt    = r_res[RES_LT];
  assign rsp_gt    = r_res[RES_GT];

endmodule
